// File: rtl/demod_integrator.sv
// Synchronous-detection integrator: splits ADC samples by switch phase, blanks post-edge
// settling samples, and presents per-window sums/counts/difference on a valid/ready port.
module demod_integrator #(
  parameter int DATA_W    = 12,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16,
  parameter int N_PERIODS = 64,
  parameter int BLANK     = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              enable,
  input  logic              switch_phase,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ACC_W-1:0]  result_sig,
  output logic [ACC_W-1:0]  result_gnd,
  output logic [ACC_W:0]    result_diff,
  output logic [CNT_W-1:0]  result_n_sig,
  output logic [CNT_W-1:0]  result_n_gnd,
  output logic              result_sat,
  output logic              overflow,
  output logic              busy
);

  localparam int PW = (N_PERIODS > 1) ? $clog2(N_PERIODS) : 1;
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam logic [PW-1:0] LAST_PERIOD = PW'(N_PERIODS - 1);
  localparam logic [BW-1:0] BLANK_LD    = BW'(BLANK);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_INTEGRATE = 2'd2} state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;

  logic sync1_q, sp_s_q, sp_d_q;
  logic rise, sw_edge;

  logic          win_start, integrating, active, closing, take, fin_sat, load;
  logic [BW-1:0] blank_q, blank_d, eff_blank;
  logic [PW-1:0] period_q, period_d;
  logic          sat_q, sat_d;

  // Per-phase final values for this cycle, index 1 = signal, 0 = ground
  logic [ACC_W-1:0] acc_fin [2];
  logic [CNT_W-1:0] cnt_fin [2];
  logic [1:0]       sat_ph;

  logic             res_valid_q, res_valid_d;
  logic [ACC_W-1:0] res_sig_q, res_sig_d, res_gnd_q, res_gnd_d;
  logic [ACC_W:0]   res_diff_q, res_diff_d;
  logic [CNT_W-1:0] res_nsig_q, res_nsig_d, res_ngnd_q, res_ngnd_d;
  logic             res_sat_q, res_sat_d;
  logic             ovf_q, ovf_d;

  assign rise    = sp_s_q & ~sp_d_q;
  assign sw_edge = sp_s_q ^ sp_d_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      sync1_q <= 1'b0;
      sp_s_q  <= 1'b0;
      sp_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      sync1_q <= switch_phase;
      sp_s_q  <= sync1_q;
      sp_d_q  <= sp_s_q;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_ARM;
      S_ARM:       if (!enable) state_d = S_IDLE;
                   else if (rise) state_d = S_INTEGRATE;
      S_INTEGRATE: if (!enable) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    win_start   = (state_q == S_ARM) && enable && rise;
    integrating = (state_q == S_INTEGRATE) && enable;
    busy_d      = (state_d != S_IDLE);
  end

  assign active  = win_start || integrating;
  assign closing = integrating && rise && (period_q == LAST_PERIOD);

  // A sample on an edge cycle sees the freshly reloaded blanking count
  assign eff_blank = sw_edge ? BLANK_LD : blank_q;
  assign take      = sample_valid && (eff_blank == '0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
      logic [ACC_W-1:0] acc_q, acc_d, base_acc, fin_acc;
      logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt, fin_cnt;
      logic [ACC_W:0]   sum;
      logic             add, sat_acc, sat_cnt;

      always_comb begin
        base_acc = win_start ? '0 : acc_q;
        base_cnt = win_start ? '0 : cnt_q;
        add      = take && (sp_s_q == 1'(gi));
        sum      = {1'b0, base_acc} + (ACC_W+1)'(sample_data);
        sat_acc  = add && sum[ACC_W];
        sat_cnt  = add && (&base_cnt);
        fin_acc  = !add ? base_acc : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
        fin_cnt  = (!add || sat_cnt) ? base_cnt : base_cnt + CNT_W'(1);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (closing) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (active) begin
          acc_d = fin_acc;
          cnt_d = fin_cnt;
        end
      end

      always_ff @(posedge clk) begin
        if (!clr) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end

      assign acc_fin[gi] = fin_acc;
      assign cnt_fin[gi] = fin_cnt;
      assign sat_ph[gi]  = sat_acc | sat_cnt;
    end
  endgenerate

  always_comb begin
    fin_sat  = (win_start ? 1'b0 : sat_q) | (|sat_ph);
    blank_d  = blank_q;
    period_d = period_q;
    sat_d    = sat_q;
    if (active) begin
      blank_d = (sample_valid && (eff_blank != '0)) ? eff_blank - BW'(1) : eff_blank;
      if (closing) begin
        period_d = '0;
        sat_d    = 1'b0;
      end else begin
        sat_d    = fin_sat;
        period_d = win_start ? '0 : (rise ? period_q + PW'(1) : period_q);
      end
    end
  end

  // Result slot: a close loads only if the slot is empty or being drained this cycle
  assign load = closing && (!res_valid_q || result_ready);

  always_comb begin
    res_valid_d = res_valid_q;
    res_sig_d   = res_sig_q;
    res_gnd_d   = res_gnd_q;
    res_diff_d  = res_diff_q;
    res_nsig_d  = res_nsig_q;
    res_ngnd_d  = res_ngnd_q;
    res_sat_d   = res_sat_q;
    ovf_d       = ovf_q | (closing && !load);
    if (load) begin
      res_valid_d = 1'b1;
      res_sig_d   = acc_fin[1];
      res_gnd_d   = acc_fin[0];
      res_diff_d  = {1'b0, acc_fin[1]} - {1'b0, acc_fin[0]};
      res_nsig_d  = cnt_fin[1];
      res_ngnd_d  = cnt_fin[0];
      res_sat_d   = fin_sat;
    end else if (res_valid_q && result_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      blank_q     <= '0;
      period_q    <= '0;
      sat_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_sig_q   <= '0;
      res_gnd_q   <= '0;
      res_diff_q  <= '0;
      res_nsig_q  <= '0;
      res_ngnd_q  <= '0;
      res_sat_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      blank_q     <= blank_d;
      period_q    <= period_d;
      sat_q       <= sat_d;
      res_valid_q <= res_valid_d;
      res_sig_q   <= res_sig_d;
      res_gnd_q   <= res_gnd_d;
      res_diff_q  <= res_diff_d;
      res_nsig_q  <= res_nsig_d;
      res_ngnd_q  <= res_ngnd_d;
      res_sat_q   <= res_sat_d;
      ovf_q       <= ovf_d;
    end
  end

  assign result_valid = res_valid_q;
  assign result_sig   = res_sig_q;
  assign result_gnd   = res_gnd_q;
  assign result_diff  = res_diff_q;
  assign result_n_sig = res_nsig_q;
  assign result_n_gnd = res_ngnd_q;
  assign result_sat   = res_sat_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_demod_integrator.sv
// Bench for demod_integrator: a 4-period nominal instance (A) driven by a free-running
// 40-cycle switch pattern, and a 16-bit saturation instance (B) driven by hand.
module tb_demod_integrator;
  localparam int DW  = 12;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int AWB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic en_a, sw_a, sv_a, rdy_a;
  logic [DW-1:0] sd_a;
  logic rv_a, rsat_a, ovf_a, busy_a;
  logic [AW-1:0] rsig_a, rgnd_a;
  logic [AW:0] rdiff_a;
  logic [CW-1:0] rns_a, rng_a;

  logic en_b, sw_b, sv_b, rdy_b;
  logic [DW-1:0] sd_b;
  logic rv_b, rsat_b, ovf_b, busy_b;
  logic [AWB-1:0] rsig_b, rgnd_b;
  logic [AWB:0] rdiff_b;
  logic [CW-1:0] rns_b, rng_b;

  demod_integrator #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .N_PERIODS(4), .BLANK(2)) dut_a (
    .clk(clk), .clr(clr), .enable(en_a), .switch_phase(sw_a), .sample_valid(sv_a),
    .sample_data(sd_a), .result_valid(rv_a), .result_ready(rdy_a), .result_sig(rsig_a),
    .result_gnd(rgnd_a), .result_diff(rdiff_a), .result_n_sig(rns_a), .result_n_gnd(rng_a),
    .result_sat(rsat_a), .overflow(ovf_a), .busy(busy_a)
  );

  demod_integrator #(.DATA_W(DW), .ACC_W(AWB), .CNT_W(CW), .N_PERIODS(1), .BLANK(0)) dut_b (
    .clk(clk), .clr(clr), .enable(en_b), .switch_phase(sw_b), .sample_valid(sv_b),
    .sample_data(sd_b), .result_valid(rv_b), .result_ready(rdy_b), .result_sig(rsig_b),
    .result_gnd(rgnd_b), .result_diff(rdiff_b), .result_n_sig(rns_b), .result_n_gnd(rng_b),
    .result_sat(rsat_b), .overflow(ovf_b), .busy(busy_b)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int sig_val, gnd_val;

  typedef struct {
    int sig_in;
    int gnd_in;
    int exp_sig;
    int exp_gnd;
    int exp_diff;
  } vec_t;

  vec_t tbl [5];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // 20/20 switch; samples at offsets 3,7,11,15,19 after each synchronized edge (2-cycle lag)
  initial begin
    int t, u, r;
    t = 0;
    sw_a = 1'b1;
    sv_a = 1'b0;
    sd_a = '0;
    forever begin
      @(negedge clk);
      u    = (t + 38) % 40;
      r    = u % 20;
      sw_a = (t % 40) < 20;
      sv_a = (r == 3) || (r == 7) || (r == 11) || (r == 15) || (r == 19);
      sd_a = DW'((u < 20) ? sig_val : gnd_val);
      t++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_valid(input int budget, input string nm, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rv_a && waited < budget);
    chk({nm, "_arrives"}, 64'(rv_a), 64'd1);
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, "_valid"}, 64'(rv_a), 64'd0);
    chk({nm, "_sig"}, 64'(rsig_a), 64'd0);
    chk({nm, "_gnd"}, 64'(rgnd_a), 64'd0);
    chk({nm, "_diff"}, 64'(rdiff_a), 64'd0);
    chk({nm, "_nsig"}, 64'(rns_a), 64'd0);
    chk({nm, "_ngnd"}, 64'(rng_a), 64'd0);
    chk({nm, "_sat"}, 64'(rsat_a), 64'd0);
    chk({nm, "_ovf"}, 64'(ovf_a), 64'd0);
    chk({nm, "_busy"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    logic [AW:0] ed;
    int w, k, last;

    tbl[0] = '{100, 60, 1200, 720, 480};
    tbl[1] = '{60, 100, 720, 1200, -480};
    tbl[2] = '{4095, 0, 49140, 0, 49140};
    tbl[3] = '{0, 4095, 0, 49140, -49140};
    tbl[4] = '{7, 7, 84, 84, 0};

    clr = 1'b0; en_a = 1'b0; rdy_a = 1'b1;
    en_b = 1'b0; sw_b = 1'b0; sv_b = 1'b0; sd_b = '0; rdy_b = 1'b1;
    sig_val = tbl[0].sig_in;
    gnd_val = tbl[0].gnd_in;
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    clr  = 1'b1;
    en_a = 1'b1;

    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valid(400, $sformatf("win%0d", i), w);
      if (i > 0) chk($sformatf("win%0d_gap", i), 64'(cyc - last), 64'd160);
      last = cyc;
      ed = (AW+1)'(tbl[i].exp_diff);
      chk($sformatf("win%0d_sig", i), 64'(rsig_a), 64'(tbl[i].exp_sig));
      chk($sformatf("win%0d_gnd", i), 64'(rgnd_a), 64'(tbl[i].exp_gnd));
      chk($sformatf("win%0d_diff", i), 64'(rdiff_a), 64'(ed));
      chk($sformatf("win%0d_nsig", i), 64'(rns_a), 64'd12);
      chk($sformatf("win%0d_ngnd", i), 64'(rng_a), 64'd12);
      chk($sformatf("win%0d_sat", i), 64'(rsat_a), 64'd0);
      $display("window %0d: sig=%0d gnd=%0d n_sig=%0d n_gnd=%0d", i, rsig_a, rgnd_a, rns_a, rng_a);
      sig_val = (i < 4) ? tbl[i+1].sig_in : 100;
      gnd_val = (i < 4) ? tbl[i+1].gnd_in : 60;
    end

    // Simultaneous: hold window 4, then pulse ready exactly on the next close
    rdy_a = 1'b0;
    repeat (158) @(negedge clk);
    chk("sim_hold_valid", 64'(rv_a), 64'd1);
    chk("sim_hold_sig", 64'(rsig_a), 64'd84);
    @(negedge clk);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("sim_valid", 64'(rv_a), 64'd1);
    chk("sim_sig", 64'(rsig_a), 64'd1200);
    chk("sim_gnd", 64'(rgnd_a), 64'd720);
    chk("sim_ovf", 64'(ovf_a), 64'd0);
    $display("simultaneous: new window loaded sig=%0d gnd=%0d", rsig_a, rgnd_a);
    sig_val = 4095;
    gnd_val = 0;
    @(negedge clk);
    rdy_a = 1'b0;
    chk("bp_drained", 64'(rv_a), 64'd0);

    // Backpressure over two windows
    wait_valid(200, "bp_first", w);
    chk("bp_first_time", 64'(w), 64'd159);
    chk("bp_first_sig", 64'(rsig_a), 64'd49140);
    sig_val = 0;
    gnd_val = 4095;
    repeat (80) @(negedge clk);
    chk("bp_hold_valid", 64'(rv_a), 64'd1);
    chk("bp_hold_sig", 64'(rsig_a), 64'd49140);
    chk("bp_hold_ovf", 64'(ovf_a), 64'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ovf_a && k < 120);
    chk("bp_ovf", 64'(ovf_a), 64'd1);
    chk("bp_ovf_time", 64'(k), 64'd80);
    chk("bp_kept_sig", 64'(rsig_a), 64'd49140);
    chk("bp_kept_gnd", 64'(rgnd_a), 64'd0);
    chk("bp_kept_valid", 64'(rv_a), 64'd1);
    $display("backpressure: overflow=%0d held sig=%0d", ovf_a, rsig_a);
    sig_val = 60;
    gnd_val = 100;
    rdy_a = 1'b1;
    @(negedge clk);
    chk("bp_xfer", 64'(rv_a), 64'd0);
    wait_valid(200, "bp_third", w);
    ed = (AW+1)'(-480);
    chk("bp_third_time", 64'(w), 64'd159);
    chk("bp_third_sig", 64'(rsig_a), 64'd720);
    chk("bp_third_gnd", 64'(rgnd_a), 64'd1200);
    chk("bp_third_diff", 64'(rdiff_a), 64'(ed));
    sig_val = 100;
    gnd_val = 60;

    // Abort mid-window, re-enable mid-high phase
    repeat (59) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy_a), 64'd0);
    repeat (29) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    chk("arm_busy", 64'(busy_a), 64'd1);
    wait_valid(300, "abort_next", w);
    chk("abort_time", 64'(w), 64'd190);
    chk("abort_sig", 64'(rsig_a), 64'd1200);
    chk("abort_nsig", 64'(rns_a), 64'd12);
    chk("abort_ngnd", 64'(rng_a), 64'd12);
    $display("abort: restarted window sig=%0d after %0d cycles", rsig_a, w);

    // Reset mid-window with a pending result and sticky overflow
    rdy_a = 1'b0;
    repeat (50) @(negedge clk);
    clr  = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    chk_zero_a("midreset");
    clr = 1'b1;
    rdy_a = 1'b1;
    repeat (9) @(negedge clk);
    chk("rst_idle_busy", 64'(busy_a), 64'd0);
    chk("rst_idle_valid", 64'(rv_a), 64'd0);
    repeat (29) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    chk("rst_arm_busy", 64'(busy_a), 64'd1);
    wait_valid(300, "rst_next", w);
    chk("rst_time", 64'(w), 64'd190);
    chk("rst_sig", 64'(rsig_a), 64'd1200);
    chk("rst_ngnd", 64'(rng_a), 64'd12);
    $display("reset: restarted window sig=%0d gnd=%0d", rsig_a, rgnd_a);

    // Saturation on the 16-bit instance: 20 x 4095 in the signal phase
    en_b = 1'b1;
    repeat (4) @(negedge clk);
    sw_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat_busy", 64'(busy_b), 64'd1);
    for (int i = 0; i < 20; i++) begin
      sv_b = 1'b1;
      sd_b = 12'd4095;
      @(negedge clk);
    end
    sv_b = 1'b0;
    sw_b = 1'b0;
    repeat (5) @(negedge clk);
    sw_b = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rv_b && k < 20);
    chk("sat_valid", 64'(rv_b), 64'd1);
    chk("sat_sig", 64'(rsig_b), 64'd65535);
    chk("sat_flag", 64'(rsat_b), 64'd1);
    chk("sat_nsig", 64'(rns_b), 64'd20);
    chk("sat_gnd", 64'(rgnd_b), 64'd0);
    chk("sat_ngnd", 64'(rng_b), 64'd0);
    chk("sat_diff", 64'(rdiff_b), 64'd65535);
    chk("sat_ovf", 64'(ovf_b), 64'd0);
    $display("saturation: sig=%0d sat=%0d n_sig=%0d", rsig_b, rsat_b, rns_b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
